recfn_to_fn_stream: RTL and testbench
=====================================

Name: recfn_to_fn_stream

Overview:
- Multi-lane, pipelined converter from HardFloat recoded format (expWidth+sigWidth+1 bits) to IEEE-754 interchange format (expWidth+sigWidth bits).
- Sits at the output boundary of float datapaths, e.g. after recoded add/mul units and before memories or external ports.
- Adds a valid/ready stream handshake, a 2-stage pipeline, per-lane sticky NaN/subnormal flags, and optional NaN canonicalisation.

Parameters:
- EXP_WIDTH, 8, exponent field width (IEEE).
- SIG_WIDTH, 24, significand width including hidden bit.
- LANES, 2, independent conversion channels sharing one handshake.
- IN_WIDTH, EXP_WIDTH+SIG_WIDTH+1, recoded word width per lane.
- OUT_WIDTH, EXP_WIDTH+SIG_WIDTH, IEEE word width per lane.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  LANES*IN_WIDTH  recoded words; lane i at [i*IN_WIDTH +: IN_WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LANES*OUT_WIDTH  IEEE words; lane i at [i*OUT_WIDTH +: OUT_WIDTH].
- flag_nan  out  LANES  sticky: lane produced a NaN.
- flag_sub  out  LANES  sticky: lane produced a subnormal or zero-exponent result.
- flags_clr  in  1  synchronous clear of both flag vectors.

Behaviour:
- Reset (reset=0, async assert, sync deassert): out_valid=0, out_data=0, flag_nan=0, flag_sub=0, both stage-valid bits 0. in_ready=1 from the first cycle after release.
- Per-lane decode:
  - sign = bit IN_WIDTH-1.
  - exp = next EXP_WIDTH+1 bits.
  - fract = low SIG_WIDTH-1 bits.
  - exp[top3]: 000 zero; 110 inf; 111 NaN.
  - sig = {~zero, fract}.
- Conversion:
  - minNormExp = 2^(EXP_WIDTH-1)+2.
  - subnormal iff exp < minNormExp.
  - dist = minNormExp-1-exp, saturated at SIG_WIDTH.
  - expOut = subnormal ? 0 : exp-minNormExp+1, forced to all-ones if NaN or inf.
  - fractOut = subnormal ? (sig>>1)>>dist : inf ? 0 : fract.
- Stage 1 registers decoded fields and class bits. Stage 2 registers packed IEEE words.
- Latency: 2 cycles from in handshake to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Handshake:
  - A stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = !s1_valid || s1 advancing; combinational from out_ready, with no other comb path.
  - out_valid and out_data are held stable while out_valid=1 and out_ready=0.
  - Pipeline full with out_ready=0 gives in_ready=0. A beat is never lost or duplicated.
- Flags:
  - On each output handshake, flag_nan[i] |= lane NaN and flag_sub[i] |= lane expOut==0 and not zero-input.
  - flags_clr clears. If flags_clr and a set occur in the same cycle, the set wins.
- Reset mid-stream discards all in-flight beats.

Optional Feature:
- Macro RECFN_CANON_NAN_EN.
- Defined: every NaN output becomes canonical quiet NaN {0, all-ones exp, 1, zeros}.
- Undefined: sign and fract payload pass through unchanged.
- Flags behave identically in both builds.

Decomposition:
- Package recfn_pkg holds:
  - localparam functions for minNormExp and clog2.
  - IN_WIDTH/OUT_WIDTH derivation.
  - Class encoding constants (CLS_ZERO, CLS_INF, CLS_NAN).
  - Struct typedef for stage-1 lane fields: sign, sExp, sig, isNaN, isInf, isZero.
- Sub-module recfn_lane_decode: combinational per-lane decode/pack, instantiated LANES times via generate.

Test Plan (float32, LANES=2):
- Lane0 33'h0_8000_0000 (1.0), lane1 33'h1_0000_0000 (-0), out_ready=1 -> two cycles later out_data lanes 32'h3F80_0000, 32'h8000_0000. Flags stay 0.
- Lane0 33'h0_C000_0000 (+inf), lane1 33'h0_E040_0000 (qNaN) -> 32'h7F80_0000 and 32'h7FC0_0000. flag_nan=2'b10.
- Lane0 33'h0_3580_0000 (min subnormal) -> 32'h0000_0001, flag_sub[0]=1. Then flags_clr with a new subnormal beat completing in the same cycle -> flag_sub[0] stays 1.
- Stream 8 beats with out_ready toggling 1,0,0,1 -> in_ready drops after 2 stalled beats, out_data stable while stalled, all 8 outputs in order, no duplicates.
- reset=0 with 2 beats in flight -> out_valid=0 immediately (async), flags 0, next output is the first beat sent after release.
- Build with RECFN_CANON_NAN_EN, lane0 33'h1_E000_0001 -> 32'h7FC0_0000. Without the macro -> 32'hFF80_0001.

Source files
------------

// File: rtl/recfn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : recfn_pkg                                                       |
// | Brief    : Shared widths, class codes and stage-1 lane fields for the      |
// |            recoded-to-IEEE stream converter.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package recfn_pkg;

    localparam int FN_EXP_WIDTH = 8;
    localparam int FN_SIG_WIDTH = 24;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int min_norm_exp(input int exp_width);
        return (1 << (exp_width - 1)) + 2;
    endfunction

    function automatic int recfn_in_width(input int exp_width, input int sig_width);
        return exp_width + sig_width + 1;
    endfunction

    function automatic int recfn_out_width(input int exp_width, input int sig_width);
        return exp_width + sig_width;
    endfunction

    // Top three bits of the recoded exponent select the special classes.
    localparam logic [2:0] CLS_ZERO = 3'b000;
    localparam logic [2:0] CLS_INF  = 3'b110;
    localparam logic [2:0] CLS_NAN  = 3'b111;

    typedef struct packed {
        logic                    sign;
        logic [FN_EXP_WIDTH:0]   s_exp;
        logic [FN_SIG_WIDTH-1:0] sig;
        logic                    is_nan;
        logic                    is_inf;
        logic                    is_zero;
    } lane_fields_t;

endpackage
`default_nettype wire

// File: rtl/recfn_lane_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : recfn_lane_decode                                               |
// | Brief    : Per-lane combinational decode of a recoded word and packing of  |
// |            registered fields into an IEEE word. RECFN_CANON_NAN_EN forces  |
// |            NaN outputs to the canonical quiet NaN.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module recfn_lane_decode
    import recfn_pkg::*;
#(
    parameter int EXP_WIDTH = FN_EXP_WIDTH,
    parameter int SIG_WIDTH = FN_SIG_WIDTH,
    parameter int IN_WIDTH  = recfn_in_width(EXP_WIDTH, SIG_WIDTH),
    parameter int OUT_WIDTH = recfn_out_width(EXP_WIDTH, SIG_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  i_rec,
    output lane_fields_t         o_dec,
    input  lane_fields_t         i_fields,
    output logic [OUT_WIDTH-1:0] o_fn,
    output logic                 o_is_nan,
    output logic                 o_is_sub
);

    localparam int                 c_min_norm_i = min_norm_exp(EXP_WIDTH);
    localparam int                 c_dist_w     = clog2(SIG_WIDTH + 1);
    localparam logic [EXP_WIDTH:0] c_min_norm   = (EXP_WIDTH + 1)'(c_min_norm_i);
    localparam logic [EXP_WIDTH:0] c_norm_bias  = (EXP_WIDTH + 1)'(c_min_norm_i - 1);
    localparam logic [EXP_WIDTH:0] c_dist_sat   = (EXP_WIDTH + 1)'(SIG_WIDTH);

    logic [EXP_WIDTH:0]   w_rec_exp;
    logic [2:0]           w_rec_cls;
    logic                 w_rec_zero;

    assign w_rec_exp  = i_rec[IN_WIDTH-2 -: EXP_WIDTH+1];
    assign w_rec_cls  = w_rec_exp[EXP_WIDTH -: 3];
    assign w_rec_zero = (w_rec_cls == CLS_ZERO);

    always_comb begin
        o_dec         = '0;
        o_dec.sign    = i_rec[IN_WIDTH-1];
        o_dec.s_exp   = w_rec_exp;
        o_dec.sig     = {~w_rec_zero, i_rec[SIG_WIDTH-2:0]};
        o_dec.is_zero = w_rec_zero;
        o_dec.is_inf  = (w_rec_cls == CLS_INF);
        o_dec.is_nan  = (w_rec_cls == CLS_NAN);
    end

    logic                 w_subnormal;
    logic [EXP_WIDTH:0]   w_dist_full;
    logic [c_dist_w-1:0]  w_dist;
    logic [SIG_WIDTH-2:0] w_sub_fract;
    logic [EXP_WIDTH-1:0] w_exp_norm;
    logic [EXP_WIDTH-1:0] w_exp_out;
    logic [SIG_WIDTH-2:0] w_fract_out;

    assign w_subnormal = (i_fields.s_exp < c_min_norm);
    assign w_dist_full = c_norm_bias - i_fields.s_exp;
    // Any distance past the significand width shifts everything out anyway.
    assign w_dist      = (w_dist_full > c_dist_sat) ? c_dist_w'(SIG_WIDTH)
                                                    : c_dist_w'(w_dist_full);
    assign w_sub_fract = i_fields.sig[SIG_WIDTH-1:1] >> w_dist;
    assign w_exp_norm  = EXP_WIDTH'(i_fields.s_exp - c_norm_bias);

    always_comb begin
        w_exp_out = w_exp_norm;
        if (i_fields.is_nan || i_fields.is_inf) begin
            w_exp_out = '1;
        end else if (w_subnormal) begin
            w_exp_out = '0;
        end

        w_fract_out = i_fields.sig[SIG_WIDTH-2:0];
        if (w_subnormal) begin
            w_fract_out = w_sub_fract;
        end else if (i_fields.is_inf) begin
            w_fract_out = '0;
        end
    end

`ifdef RECFN_CANON_NAN_EN
    assign o_fn = i_fields.is_nan ? {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-2){1'b0}}}
                                  : {i_fields.sign, w_exp_out, w_fract_out};
`else
    assign o_fn = {i_fields.sign, w_exp_out, w_fract_out};
`endif

    assign o_is_nan = i_fields.is_nan;
    assign o_is_sub = (w_exp_out == '0) && !i_fields.is_zero;

endmodule
`default_nettype wire

// File: rtl/recfn_to_fn_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : recfn_to_fn_stream                                              |
// | Brief    : Multi-lane 2-stage valid/ready converter from recoded float to  |
// |            IEEE words with sticky NaN/subnormal flags. Optional macro      |
// |            RECFN_CANON_NAN_EN canonicalises NaN outputs.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module recfn_to_fn_stream
    import recfn_pkg::*;
#(
    parameter int EXP_WIDTH = FN_EXP_WIDTH,
    parameter int SIG_WIDTH = FN_SIG_WIDTH,
    parameter int LANES     = 2,
    parameter int IN_WIDTH  = recfn_in_width(EXP_WIDTH, SIG_WIDTH),
    parameter int OUT_WIDTH = recfn_out_width(EXP_WIDTH, SIG_WIDTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*IN_WIDTH-1:0]  in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*OUT_WIDTH-1:0] out_data,
    output logic [LANES-1:0]           flag_nan,
    output logic [LANES-1:0]           flag_sub,
    input  logic                       flags_clr
);

    logic                       r_s1_valid;
    logic                       r_s2_valid;
    logic                       w_s2_ready;
    logic                       w_out_fire;
    lane_fields_t               w_dec       [LANES];
    lane_fields_t               r_s1_fields [LANES];
    logic [LANES*OUT_WIDTH-1:0] w_pack_data;
    logic [LANES*OUT_WIDTH-1:0] r_out_data;
    logic [LANES-1:0]           w_pack_nan;
    logic [LANES-1:0]           w_pack_sub;
    logic [LANES-1:0]           r_s2_nan;
    logic [LANES-1:0]           r_s2_sub;
    logic [LANES-1:0]           r_flag_nan;
    logic [LANES-1:0]           r_flag_sub;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            recfn_lane_decode #(
                .EXP_WIDTH (EXP_WIDTH),
                .SIG_WIDTH (SIG_WIDTH),
                .IN_WIDTH  (IN_WIDTH),
                .OUT_WIDTH (OUT_WIDTH)
            ) u_lane (
                .i_rec    (in_data[i*IN_WIDTH +: IN_WIDTH]),
                .o_dec    (w_dec[i]),
                .i_fields (r_s1_fields[i]),
                .o_fn     (w_pack_data[i*OUT_WIDTH +: OUT_WIDTH]),
                .o_is_nan (w_pack_nan[i]),
                .o_is_sub (w_pack_sub[i])
            );
        end
    endgenerate

    // A stage may load when empty or when its occupant leaves this same cycle.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_fields[i] <= '0;
            end
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    r_s1_fields[i] <= w_dec[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_s2_nan   <= '0;
            r_s2_sub   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_pack_data;
                r_s2_nan   <= w_pack_nan;
                r_s2_sub   <= w_pack_sub;
            end
        end
    end

    // Clear is applied first so a same-cycle set survives it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag_nan <= '0;
            r_flag_sub <= '0;
        end else begin
            r_flag_nan <= (flags_clr ? '0 : r_flag_nan) | (w_out_fire ? r_s2_nan : '0);
            r_flag_sub <= (flags_clr ? '0 : r_flag_sub) | (w_out_fire ? r_s2_sub : '0);
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign flag_nan  = r_flag_nan;
    assign flag_sub  = r_flag_sub;

endmodule
`default_nettype wire

// File: tb/tb_recfn_to_fn_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_recfn_to_fn_stream                                           |
// | Brief    : Self-checking bench for recfn_to_fn_stream (float32, 2 lanes).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_recfn_to_fn_stream;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [65:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  flag_nan;
    logic [1:0]  flag_sub;
    logic        flags_clr;

    int checks = 0;
    int errors = 0;

    recfn_to_fn_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flag_nan  (flag_nan),
        .flag_sub  (flag_sub),
        .flags_clr (flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [65:0] din;
        logic [63:0] dout;
        logic [1:0]  nan;
        logic [1:0]  sub;
    } vec_t;

`ifdef RECFN_CANON_NAN_EN
    localparam logic [31:0] c_neg_nan_out = 32'h7FC0_0000;
`else
    localparam logic [31:0] c_neg_nan_out = 32'hFF80_0001;
`endif

    localparam int c_nv = 7;
    vec_t vt [c_nv];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [65:0] s_in  [8];
    logic [63:0] s_exp [8];
    int          sent;
    int          rcvd;
    logic        stalled;
    logic        saw_block;
    logic [63:0] hold_data;

    initial begin
        // {lane1, lane0}
        vt[0] = '{{33'h1_0000_0000, 33'h0_8000_0000}, {32'h8000_0000, 32'h3F80_0000}, 2'b00, 2'b00};
        vt[1] = '{{33'h0_E040_0000, 33'h0_C000_0000}, {32'h7FC0_0000, 32'h7F80_0000}, 2'b10, 2'b00};
        vt[2] = '{{33'h0_8000_0000, 33'h0_3580_0000}, {32'h3F80_0000, 32'h0000_0001}, 2'b00, 2'b01};
        vt[3] = '{{33'h0_40FF_FFFF, 33'h1_E000_0001}, {32'h007F_FFFF, c_neg_nan_out}, 2'b01, 2'b10};
        vt[4] = '{{33'h1_BFFF_FFFF, 33'h0_4100_0000}, {32'hFF7F_FFFF, 32'h0080_0000}, 2'b00, 2'b00};
        vt[5] = '{{33'h0_4040_0000, 33'h1_2000_0000}, {32'h0030_0000, 32'h8000_0000}, 2'b00, 2'b11};
        vt[6] = '{{33'h0_0000_0000, 33'h1_C000_0000}, {32'h0000_0000, 32'hFF80_0000}, 2'b00, 2'b00};

        for (int k = 0; k < 8; k++) begin
            s_in[k]  = {1'b1, 9'h101, 23'(3 * k + 1), 1'b0, 9'h100, 23'(k)};
            s_exp[k] = {32'hC000_0000 | 32'(3 * k + 1), 32'h3F80_0000 | 32'(k)};
        end

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_flags", 64'({flag_nan, flag_sub}), 64'd0);
        reset = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < c_nv; k++) begin
            in_data   = vt[k].din;
            in_valid  = 1'b1;
            flags_clr = 1'b1;
            tick();
            in_valid  = 1'b0;
            flags_clr = 1'b0;
            check($sformatf("v%0d_latency", k), 64'(out_valid), 64'd0);
            check($sformatf("v%0d_clr", k), 64'({flag_nan, flag_sub}), 64'd0);
            tick();
            check($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_data", k), out_data, vt[k].dout);
            tick();
            check($sformatf("v%0d_nan", k), 64'(flag_nan), 64'(vt[k].nan));
            check($sformatf("v%0d_sub", k), 64'(flag_sub), 64'(vt[k].sub));
        end

        // Clear in the same cycle as a subnormal handshake: set wins on lane 0.
        in_data  = {33'h0_4040_0000, 33'h0_8000_0000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("clr_pre_sub", 64'(flag_sub), 64'd2);
        in_data  = {33'h0_8000_0000, 33'h0_3580_0000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_beat_data", out_data, {32'h3F80_0000, 32'h0000_0001});
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_set_wins", 64'(flag_sub), 64'd1);

        // Back-pressured stream with out_ready pattern 1,0,0,1.
        sent      = 0;
        rcvd      = 0;
        stalled   = 1'b0;
        saw_block = 1'b0;
        hold_data = '0;
        for (int cyc = 0; cyc < 64 && rcvd < 8; cyc++) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            in_valid  = (sent < 8);
            in_data   = (sent < 8) ? s_in[sent] : '0;
            #1;
            check("strm_ready", 64'(in_ready), 64'(((sent - rcvd) < 2) || out_ready));
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (stalled) begin
                check("strm_hold_valid", 64'(out_valid), 64'd1);
                check("strm_hold_data", out_data, hold_data);
            end
            if (out_valid && out_ready) begin
                check($sformatf("strm_data%0d", rcvd), out_data, s_exp[rcvd]);
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            stalled   = out_valid && !out_ready;
            hold_data = out_data;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("strm_count", 64'(rcvd), 64'd8);
        check("strm_blocked", 64'(saw_block), 64'd1);
        #1;
        check("strm_drained", 64'(out_valid), 64'd0);

        // Reset with two beats in flight; flag_sub[0] is still set from above.
        tick();
        in_data  = {33'h0_C000_0000, 33'h0_E040_0000};
        in_valid = 1'b1;
        tick();
        in_data  = {33'h1_8000_0000, 33'h0_4040_0000};
        tick();
        in_valid = 1'b0;
        check("inflight_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", out_data, 64'd0);
        check("async_flags", 64'({flag_nan, flag_sub}), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        in_data  = {33'h1_0000_0000, 33'h0_8000_0000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_no_stale", 64'(out_valid), 64'd0);
        tick();
        check("post_rst_first_valid", 64'(out_valid), 64'd1);
        check("post_rst_first_data", out_data, {32'h8000_0000, 32'h3F80_0000});
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
